// File: rtl/jelly2_interval_timer_pkg.sv
// rtl/jelly2_interval_timer_pkg.sv - register map and CTL bit positions for the interval timer array
package jelly2_interval_timer_pkg;

    // per-channel register offsets
    localparam logic [1:0] REG_CTL        = 2'd0;
    localparam logic [1:0] REG_COMPARE    = 2'd1;
    localparam logic [1:0] REG_COUNTER    = 2'd2;
    localparam logic [1:0] REG_STATUS     = 2'd3;

    // global block register offsets
    localparam logic [1:0] REG_PRESCALE   = 2'd0;
    localparam logic [1:0] REG_IRQ_STATUS = 2'd1;

    localparam int CTL_EN      = 0;
    localparam int CTL_ONESHOT = 1;
    localparam int CTL_IRQ_EN  = 2;
    localparam int CTL_WIDTH   = 3;

endpackage

// File: rtl/jelly2_interval_timer_ch.sv
// rtl/jelly2_interval_timer_ch.sv - one timer channel: control, compare, counter, sticky status, irq
module jelly2_interval_timer_ch
    import jelly2_interval_timer_pkg::*;
    #(
        parameter int COUNTER_WIDTH = 32,
        parameter int DAT_WIDTH     = 32,
        parameter int IRQ_LEVEL     = 0
    )
    (
        input  logic                      reset,
        input  logic                      clk,
        input  logic                      tick,
        input  logic                      wr_ctl,
        input  logic                      wr_compare,
        input  logic                      wr_counter,
        input  logic                      wr_status,
        input  logic [DAT_WIDTH-1:0]      wr_dat,
        input  logic [DAT_WIDTH-1:0]      wr_mask,
        output logic [CTL_WIDTH-1:0]      ctl,
        output logic [COUNTER_WIDTH-1:0]  compare,
        output logic [COUNTER_WIDTH-1:0]  counter,
        output logic                      expired,
        output logic                      irq
    );

    logic                      expire;
    logic                      irq_pulse;
    logic [CTL_WIDTH-1:0]      ctl_base;
    logic [CTL_WIDTH-1:0]      ctl_next;
    logic [COUNTER_WIDTH-1:0]  counter_base;
    logic [COUNTER_WIDTH-1:0]  counter_next;
    logic [COUNTER_WIDTH-1:0]  compare_next;
    logic                      unused_wr;

    assign expire = tick && ctl[CTL_EN] && (counter == compare);

    // timebase result first; written byte lanes then override it
    always_comb begin
        ctl_base = ctl;
        if (expire && ctl[CTL_ONESHOT]) begin
            ctl_base[CTL_EN] = 1'b0;
        end
        counter_base = counter;
        if (expire) begin
            counter_base = '0;
        end else if (tick && ctl[CTL_EN]) begin
            counter_base = counter + COUNTER_WIDTH'(1);
        end
    end

    assign ctl_next     = wr_ctl ? ((ctl_base & ~wr_mask[CTL_WIDTH-1:0])
                                  | (wr_dat[CTL_WIDTH-1:0] & wr_mask[CTL_WIDTH-1:0])) : ctl_base;
    assign counter_next = wr_counter ? ((counter_base & ~wr_mask[COUNTER_WIDTH-1:0])
                                  | (wr_dat[COUNTER_WIDTH-1:0] & wr_mask[COUNTER_WIDTH-1:0])) : counter_base;
    assign compare_next = wr_compare ? ((compare & ~wr_mask[COUNTER_WIDTH-1:0])
                                  | (wr_dat[COUNTER_WIDTH-1:0] & wr_mask[COUNTER_WIDTH-1:0])) : compare;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl       <= '0;
            compare   <= '0;
            counter   <= '0;
            expired   <= 1'b0;
            irq_pulse <= 1'b0;
        end else begin
            ctl       <= ctl_next;
            compare   <= compare_next;
            counter   <= counter_next;
            if (expire) begin
                expired <= 1'b1;
            end else if (wr_status && wr_mask[0] && wr_dat[0]) begin
                expired <= 1'b0;
            end
            irq_pulse <= expire && ctl[CTL_IRQ_EN];
        end
    end

    assign irq = (IRQ_LEVEL != 0) ? (expired && ctl[CTL_IRQ_EN]) : irq_pulse;

    assign unused_wr = ^{wr_dat, wr_mask};

endmodule

// File: rtl/jelly2_interval_timer_array.sv
// rtl/jelly2_interval_timer_array.sv - NUM_CH interval timers on a shared prescaler with a Wishbone slave
module jelly2_interval_timer_array
    import jelly2_interval_timer_pkg::*;
    #(
        parameter int NUM_CH         = 4,
        parameter int WB_ADR_WIDTH   = 5,
        parameter int WB_DAT_WIDTH   = 32,
        parameter int COUNTER_WIDTH  = 32,
        parameter int PRESCALE_WIDTH = 16,
        parameter int IRQ_LEVEL      = 0
    )
    (
        input  logic                        reset,
        input  logic                        clk,
        input  logic                        cke,
        input  logic [WB_ADR_WIDTH-1:0]     s_wb_adr_i,
        input  logic [WB_DAT_WIDTH-1:0]     s_wb_dat_i,
        output logic [WB_DAT_WIDTH-1:0]     s_wb_dat_o,
        input  logic                        s_wb_we_i,
        input  logic [WB_DAT_WIDTH/8-1:0]   s_wb_sel_i,
        input  logic                        s_wb_stb_i,
        output logic                        s_wb_ack_o,
        output logic [NUM_CH-1:0]           irq,
        output logic                        irq_any
    );

    localparam int BLK_W = WB_ADR_WIDTH - 2;
    localparam int SEL_W = WB_DAT_WIDTH / 8;

    logic [BLK_W-1:0]           blk;
    logic [1:0]                 regsel;
    logic                       wr_en;
    logic                       glb_sel;
    logic [WB_DAT_WIDTH-1:0]    wr_mask;
    logic [PRESCALE_WIDTH-1:0]  prescale;
    logic [PRESCALE_WIDTH-1:0]  pre_cnt;
    logic                       tick;

    logic [CTL_WIDTH-1:0]       ch_ctl     [NUM_CH];
    logic [COUNTER_WIDTH-1:0]   ch_compare [NUM_CH];
    logic [COUNTER_WIDTH-1:0]   ch_counter [NUM_CH];
    logic [NUM_CH-1:0]          ch_expired;

    assign blk        = s_wb_adr_i[WB_ADR_WIDTH-1:2];
    assign regsel     = s_wb_adr_i[1:0];
    assign wr_en      = s_wb_stb_i && s_wb_we_i;
    assign glb_sel    = (blk == BLK_W'(NUM_CH));
    assign s_wb_ack_o = s_wb_stb_i;

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < SEL_W; i++) begin
            wr_mask[i*8 +: 8] = {8{s_wb_sel_i[i]}};
        end
    end

    // tick is combinational so a PRESCALE write in the tick cycle still delivers it
    assign tick = cke && (pre_cnt == prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
            pre_cnt  <= '0;
        end else if (wr_en && glb_sel && regsel == REG_PRESCALE) begin
            prescale <= (prescale & ~wr_mask[PRESCALE_WIDTH-1:0])
                      | (s_wb_dat_i[PRESCALE_WIDTH-1:0] & wr_mask[PRESCALE_WIDTH-1:0]);
            pre_cnt  <= '0;
        end else if (cke) begin
            pre_cnt  <= tick ? '0 : pre_cnt + PRESCALE_WIDTH'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_wr;
        assign ch_wr = wr_en && (blk == BLK_W'(i));

        jelly2_interval_timer_ch
            #(
                .COUNTER_WIDTH (COUNTER_WIDTH),
                .DAT_WIDTH     (WB_DAT_WIDTH),
                .IRQ_LEVEL     (IRQ_LEVEL)
            )
        u_ch
            (
                .reset         (reset),
                .clk           (clk),
                .tick          (tick),
                .wr_ctl        (ch_wr && regsel == REG_CTL),
                .wr_compare    (ch_wr && regsel == REG_COMPARE),
                .wr_counter    (ch_wr && regsel == REG_COUNTER),
                .wr_status     (ch_wr && regsel == REG_STATUS),
                .wr_dat        (s_wb_dat_i),
                .wr_mask       (wr_mask),
                .ctl           (ch_ctl[i]),
                .compare       (ch_compare[i]),
                .counter       (ch_counter[i]),
                .expired       (ch_expired[i]),
                .irq           (irq[i])
            );
    end

    assign irq_any = |irq;

    always_comb begin
        s_wb_dat_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (blk == BLK_W'(i)) begin
                case (regsel)
                    REG_CTL:     s_wb_dat_o[CTL_WIDTH-1:0]     = ch_ctl[i];
                    REG_COMPARE: s_wb_dat_o[COUNTER_WIDTH-1:0] = ch_compare[i];
                    REG_COUNTER: s_wb_dat_o[COUNTER_WIDTH-1:0] = ch_counter[i];
                    default:     s_wb_dat_o[0]                 = ch_expired[i];
                endcase
            end
        end
        if (glb_sel) begin
            case (regsel)
                REG_PRESCALE:   s_wb_dat_o[PRESCALE_WIDTH-1:0] = prescale;
                REG_IRQ_STATUS: s_wb_dat_o[NUM_CH-1:0]         = ch_expired;
                default:        ;
            endcase
        end
    end

endmodule

// File: tb/tb_jelly2_interval_timer_array.sv
// tb/tb_jelly2_interval_timer_array.sv - pulse and level instances against a behavioural timer model
module tb_jelly2_interval_timer_array;

    localparam int NCH = 4;
    localparam int CW  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cke = 1'b1;
    logic [4:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic        stb = 1'b0;

    logic [31:0] dat_p, dat_l;
    logic        ack_p, ack_l;
    logic [3:0]  irq_p, irq_l;
    logic        any_p, any_l;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jelly2_interval_timer_array #(.NUM_CH(NCH), .WB_ADR_WIDTH(5), .WB_DAT_WIDTH(32),
        .COUNTER_WIDTH(CW), .PRESCALE_WIDTH(16), .IRQ_LEVEL(0)) dut_p (
        .reset(reset), .clk(clk), .cke(cke), .s_wb_adr_i(adr), .s_wb_dat_i(dat_i),
        .s_wb_dat_o(dat_p), .s_wb_we_i(we), .s_wb_sel_i(sel), .s_wb_stb_i(stb),
        .s_wb_ack_o(ack_p), .irq(irq_p), .irq_any(any_p));

    jelly2_interval_timer_array #(.NUM_CH(NCH), .WB_ADR_WIDTH(5), .WB_DAT_WIDTH(32),
        .COUNTER_WIDTH(CW), .PRESCALE_WIDTH(16), .IRQ_LEVEL(1)) dut_l (
        .reset(reset), .clk(clk), .cke(cke), .s_wb_adr_i(adr), .s_wb_dat_i(dat_i),
        .s_wb_dat_o(dat_l), .s_wb_we_i(we), .s_wb_sel_i(sel), .s_wb_stb_i(stb),
        .s_wb_ack_o(ack_l), .irq(irq_l), .irq_any(any_l));

    // behavioural model: integer registers advanced once per clock
    int unsigned m_ctl [NCH];
    int unsigned m_cmp [NCH];
    int unsigned m_cnt [NCH];
    bit          m_exp [NCH];
    bit          m_pulse [NCH];
    int unsigned m_pre, m_pcnt;

    function automatic int unsigned merge(int unsigned old, int unsigned d, logic [3:0] s, int unsigned wmask);
        int unsigned m = 0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8*b));
        return ((old & ~m) | (d & m)) & wmask;
    endfunction

    always @(posedge clk) begin : model_step
        bit tick, wr, ev, en;
        int unsigned blk, r;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_ctl[c] = 0; m_cmp[c] = 0; m_cnt[c] = 0; m_exp[c] = 0; m_pulse[c] = 0;
            end
            m_pre = 0; m_pcnt = 0;
        end else begin
            tick = cke && (m_pcnt == m_pre);
            wr   = stb && we;
            blk  = adr >> 2;
            r    = adr & 3;
            for (int c = 0; c < NCH; c++) begin
                en = (m_ctl[c] & 1) != 0;
                ev = tick && en && (m_cnt[c] == m_cmp[c]);
                m_pulse[c] = ev && ((m_ctl[c] & 4) != 0);
                if (ev) begin
                    m_cnt[c] = 0;
                    m_exp[c] = 1;
                    if ((m_ctl[c] & 2) != 0) m_ctl[c] = m_ctl[c] & ~32'd1;
                end else if (tick && en) begin
                    m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
                end
                if (wr && blk == c) begin
                    case (r)
                        0: m_ctl[c] = merge(m_ctl[c], dat_i, sel, 7);
                        1: m_cmp[c] = merge(m_cmp[c], dat_i, sel, (1 << CW) - 1);
                        2: m_cnt[c] = merge(m_cnt[c], dat_i, sel, (1 << CW) - 1);
                        default: if (sel[0] && dat_i[0] && !ev) m_exp[c] = 0;
                    endcase
                end
            end
            if (cke) m_pcnt = tick ? 0 : m_pcnt + 1;
            if (wr && blk == NCH && r == 0) begin
                m_pre  = merge(m_pre, dat_i, sel, 32'hFFFF);
                m_pcnt = 0;
            end
        end
    end

    function automatic logic [31:0] exp_rd(int unsigned a);
        int unsigned blk = a >> 2;
        int unsigned r   = a & 3;
        logic [31:0] v   = '0;
        if (blk < NCH) begin
            case (r)
                0: v = m_ctl[blk];
                1: v = m_cmp[blk];
                2: v = m_cnt[blk];
                default: v = m_exp[blk];
            endcase
        end else if (blk == NCH) begin
            if (r == 0) v = m_pre;
            else if (r == 1) for (int c = 0; c < NCH; c++) v[c] = m_exp[c];
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] ep, el;
        if (started) begin
            for (int c = 0; c < NCH; c++) begin
                ep[c] = m_pulse[c];
                el[c] = m_exp[c] && ((m_ctl[c] & 4) != 0);
            end
            check("rdata_pulse", dat_p, exp_rd(adr));
            check("rdata_level", dat_l, exp_rd(adr));
            check("ack", {30'd0, ack_p, ack_l}, {30'd0, stb, stb});
            check("irq_pulse", {28'd0, irq_p}, {28'd0, ep});
            check("irq_level", {28'd0, irq_l}, {28'd0, el});
            check("irq_any_pulse", {31'd0, any_p}, {31'd0, |ep});
            check("irq_any_level", {31'd0, any_l}, {31'd0, |el});
        end
    end

    task automatic wr(input int a, input int unsigned d);
        @(posedge clk); #1;
        adr = a[4:0]; dat_i = d; sel = 4'hF; we = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        @(posedge clk); #1;
        adr = a[4:0]; we = 1'b0; stb = 1'b1;
        @(negedge clk);
        d = dat_p;
        @(posedge clk); #1;
        stb = 1'b0;
    endtask

    task automatic wait_irq(input int ch, input bit lvl, input int maxc, output int c);
        c = -1;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if ((lvl ? irq_l[ch] : irq_p[ch]) === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_irq%0d: got no irq, expected one within %0d cycles", ch, maxc);
        end
    endtask

    initial begin
        logic [31:0] d;
        int c0, c1, c2;

        repeat (3) @(posedge clk);
        started = 1'b1;
        #1 reset = 1'b0;

        for (int a = 0; a < 32; a++) begin
            rd(a, d);
            check($sformatf("reset_read_%0d", a), d, 32'd0);
        end
        check("reset_irq", {28'd0, irq_p}, 32'd0);
        check("reset_irq_any", {31'd0, any_p}, 32'd0);

        // ch0 periodic pulse, PRESCALE=0, COMPARE=3
        wr(1, 3);
        wr(0, 5);
        wait_irq(0, 0, 20, c1);
        wait_irq(0, 0, 20, c2);
        check("ch0_period", c2 - c1, 4);
        rd(3, d);
        check("ch0_status_set", d, 1);
        wr(0, 0);
        wr(3, 1);
        rd(3, d);
        check("ch0_status_clr", d, 0);

        // ch1 one-shot level irq with PRESCALE=2
        wr(16, 2);
        wr(5, 1);
        wr(4, 7);
        c0 = cyc;
        wait_irq(1, 1, 12, c1);
        check("ch1_oneshot_delay", c1 - c0, 5);
        rd(4, d);
        check("ch1_ctl_en_cleared", d, 6);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ch1_level_held", {31'd0, irq_l[1]}, 1);
        wr(7, 1);
        @(negedge clk);
        check("ch1_level_cleared", {31'd0, irq_l[1]}, 0);

        // all channels periodic, COMPARE = channel index
        wr(16, 0);
        for (int c = 0; c < NCH; c++) begin
            wr(c*4 + 1, c);
            wr(c*4, 5);
        end
        for (int k = 0; k < 20; k++) rd(17, d);
        for (int c = 0; c < NCH; c++) begin
            wr(c*4, 0);
            wr(c*4 + 3, 1);
        end
        rd(17, d);
        check("irq_status_cleared", d, 0);

        // ch2: counter write on the expire edge wins, then wraps through 2^8
        wr(10, 0);
        wr(9, 5);
        wr(8, 5);
        repeat (4) @(posedge clk);
        wr(10, 10);
        wr(8, 0);
        rd(10, d);
        check("ch2_counter_write_wins", d, 12);
        rd(11, d);
        check("ch2_expired_on_write", d, 1);
        wr(11, 1);
        wr(8, 5);
        c0 = cyc;
        wait_irq(2, 0, 400, c1);
        check("ch2_wrap_delay", c1 - c0, 250);
        wr(8, 0);

        // ch3: status clear on the expire edge loses
        wr(15, 1);
        wr(14, 0);
        wr(13, 2);
        wr(12, 1);
        repeat (1) @(posedge clk);
        wr(15, 1);
        wr(12, 0);
        rd(15, d);
        check("ch3_set_beats_clear", d, 1);

        // cke low freezes the counter while the bus stays live
        cke = 1'b0;
        wr(1, 200);
        wr(2, 7);
        wr(0, 1);
        repeat (20) @(posedge clk);
        rd(2, d);
        check("cke_low_counter_hold", d, 7);
        cke = 1'b1;
        wr(0, 0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 499) == 0);
            cke   = ($urandom_range(0, 9) != 0);
            stb   = ($urandom_range(0, 2) != 0);
            we    = ($urandom_range(0, 3) == 0);
            adr   = 5'($urandom_range(0, 31));
            sel   = 4'($urandom);
            dat_i = $urandom;
            if (adr == 5'd16) dat_i = $urandom_range(0, 3);
            else if (adr[1:0] == 2'd1) dat_i = $urandom_range(0, 15);
        end
        @(posedge clk); #1;
        reset = 1'b0; stb = 1'b0; we = 1'b0; cke = 1'b1;
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
